vqc_layer_sequencer: RTL and testbench

- Sequences a variational circuit of up to MAX_LAYERS single-qubit gate layers over one shared 1-qubit complex matmul datapath.
- Holds the per-layer 2x2 complex gate matrices (8 words each) in an internal gate memory, loaded by a host configuration port.
- On start, loads the initial state vector, applies one layer at a time, feeding back each result, and presents the final state with a done pulse.
- Sits between the host/parameter-update logic and the matmul instance.

---
 rtl/vqc_layer_sequencer.sv | 112 +++++++++++
 tb/tb_vqc_layer_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vqc_layer_sequencer.sv
// rtl/vqc_layer_sequencer.sv - sequences single-qubit gate layers over a shared 1-qubit complex matmul
module vqc_layer_sequencer #(
  parameter int N          = 16,
  parameter int MAX_LAYERS = 8,
  parameter int MM_LAT     = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [$clog2(MAX_LAYERS+1)-1:0]   n_layers,
  input  logic [0:3][N-1:0]                 init_state,
  input  logic                              cfg_we,
  input  logic [$clog2(MAX_LAYERS*8)-1:0]   cfg_addr,
  input  logic [N-1:0]                      cfg_data,
  output logic                              cfg_err,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(MAX_LAYERS)-1:0]     layer_idx,
  output logic [0:7][N-1:0]                 mm_matrix,
  output logic [0:3][N-1:0]                 mm_vector,
  input  logic [0:3][N-1:0]                 mm_result,
  output logic [0:3][N-1:0]                 psi_out,
  output logic                              psi_valid
);

  localparam int LW    = $clog2(MAX_LAYERS+1);
  localparam int CW    = (MM_LAT > 0) ? $clog2(MM_LAT+1) : 1;
  localparam int DEPTH = MAX_LAYERS*8;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_DONE} state_t;

  state_t          state, state_nx;
  logic [LW-1:0]   num_layers;
  logic [CW-1:0]   wait_cnt;
  logic [0:3][N-1:0] psi;
  logic [N-1:0]    gate_mem [DEPTH];

  logic capture, last_layer, wr_window, addr_ok;

  assign capture    = (wait_cnt == CW'(MM_LAT));
  assign last_layer = (32'(layer_idx) + 32'd1 == 32'(num_layers));
  assign wr_window  = (state == S_IDLE) || (state == S_DONE);
  assign addr_ok    = (32'(cfg_addr) < DEPTH);

  assign busy      = (state == S_LOAD) || (state == S_EXEC);
  assign done      = (state == S_DONE);
  assign mm_vector = psi;
  assign psi_out   = psi;

  for (genvar e = 0; e < 8; e++) begin : g_mat
    assign mm_matrix[e] = gate_mem[{layer_idx, 3'(e)}];
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_LOAD;
      S_LOAD: state_nx = S_EXEC;
      // An empty run still spends one EXEC cycle so done lands after the second edge.
      S_EXEC: if (num_layers == '0 || (capture && last_layer)) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      num_layers <= '0;
      wait_cnt   <= '0;
      layer_idx  <= '0;
      psi        <= '0;
      psi_valid  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state   <= state_nx;
      cfg_err <= cfg_we && !(wr_window && addr_ok);
      case (state)
        S_IDLE: begin
          if (start) begin
            num_layers <= (32'(n_layers) > MAX_LAYERS) ? LW'(MAX_LAYERS) : n_layers;
            psi_valid  <= 1'b0;
          end
        end
        S_LOAD: begin
          psi       <= init_state;
          layer_idx <= '0;
          wait_cnt  <= '0;
        end
        S_EXEC: begin
          if (num_layers != '0) begin
            if (capture) begin
              psi      <= mm_result;
              wait_cnt <= '0;
              if (!last_layer) layer_idx <= layer_idx + 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        S_DONE: psi_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  // Gate memory survives reset; writes only land outside a run and in range.
  always_ff @(posedge clk) begin
    if (cfg_we && wr_window && addr_ok) gate_mem[cfg_addr] <= cfg_data;
  end

endmodule

// File: tb/tb_vqc_layer_sequencer.sv
// tb/tb_vqc_layer_sequencer.sv - randomized bench for vqc_layer_sequencer, two builds against a layer model
module tb_vqc_layer_sequencer;

  typedef logic [0:3][15:0] vec_t;
  typedef logic [0:7][15:0] mat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [3:0] n_a = '0;
  logic [2:0] n_b = '0;
  vec_t       init_state = '0;
  logic       cfg_we = 1'b0;
  logic [5:0] cfg_addr = '0;
  logic [15:0] cfg_data = '0;

  logic cfg_err_a, busy_a, done_a, psi_valid_a;
  logic cfg_err_b, busy_b, done_b, psi_valid_b;
  logic [2:0] layer_idx_a, layer_idx_b;
  mat_t mm_matrix_a, mm_matrix_b;
  vec_t mm_vector_a, mm_vector_b, mm_result_a, mm_result_b, psi_out_a, psi_out_b;
  vec_t pipe1, pipe2;

  int errors = 0;
  int checks = 0;
  logic [15:0] mem_a [64];
  logic [15:0] mem_b [48];

  vqc_layer_sequencer #(.N(16), .MAX_LAYERS(8), .MM_LAT(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .n_layers(n_a), .init_state(init_state),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err_a),
    .busy(busy_a), .done(done_a), .layer_idx(layer_idx_a), .mm_matrix(mm_matrix_a),
    .mm_vector(mm_vector_a), .mm_result(mm_result_a), .psi_out(psi_out_a), .psi_valid(psi_valid_a));

  vqc_layer_sequencer #(.N(16), .MAX_LAYERS(6), .MM_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .n_layers(n_b), .init_state(init_state),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err_b),
    .busy(busy_b), .done(done_b), .layer_idx(layer_idx_b), .mm_matrix(mm_matrix_b),
    .mm_vector(mm_vector_b), .mm_result(mm_result_b), .psi_out(psi_out_b), .psi_valid(psi_valid_b));

  // Q2.14 complex 2x2 times 2-vector, truncating shift back to Q2.14.
  function automatic vec_t cmv(input mat_t m, input vec_t v);
    vec_t r;
    longint re, im, mr, mi, vr, vi;
    for (int row = 0; row < 2; row++) begin
      re = 0; im = 0;
      for (int col = 0; col < 2; col++) begin
        mr = longint'($signed(m[row*4+col*2]));
        mi = longint'($signed(m[row*4+col*2+1]));
        vr = longint'($signed(v[col*2]));
        vi = longint'($signed(v[col*2+1]));
        re += mr*vr - mi*vi;
        im += mr*vi + mi*vr;
      end
      r[row*2]   = 16'(re >>> 14);
      r[row*2+1] = 16'(im >>> 14);
    end
    return r;
  endfunction

  assign mm_result_a = cmv(mm_matrix_a, mm_vector_a);
  always_ff @(posedge clk) begin
    pipe1 <= cmv(mm_matrix_b, mm_vector_b);
    pipe2 <= pipe1;
  end
  assign mm_result_b = pipe2;

  function automatic vec_t model_run(input bit use_b, input int layers, input vec_t init);
    vec_t p = init;
    mat_t m;
    for (int l = 0; l < layers; l++) begin
      for (int e = 0; e < 8; e++) m[e] = use_b ? mem_b[l*8+e] : mem_a[l*8+e];
      p = cmv(m, p);
    end
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic cfg_write(input int addr, input logic [15:0] data);
    cfg_we = 1'b1; cfg_addr = 6'(addr); cfg_data = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("cfg_err_a", cfg_err_a, 1'b0);
    check("cfg_err_b", cfg_err_b, addr >= 48);
    mem_a[addr] = data;
    if (addr < 48) mem_b[addr] = data;
  endtask

  task automatic set_layer(input int layer, input mat_t m);
    for (int e = 0; e < 8; e++) cfg_write(layer*8 + e, m[e]);
  endtask

  task automatic run(input int na, input int nb, input vec_t init, input bit bw, input bit sw);
    int la, lb, ea, eb, da, db, ba, bb, kend, wa;
    vec_t pa, pb;
    la = (na > 8) ? 8 : na;
    lb = (nb > 6) ? 6 : nb;
    ea = (la == 0) ? 2 : 1 + la;
    eb = (lb == 0) ? 2 : 1 + lb*3;
    kend = ((ea > eb) ? ea : eb) + 1;
    da = -1; db = -1; ba = 0; bb = 0;
    n_a = 4'(na); n_b = 3'(nb); init_state = init; start = 1'b1;
    if (sw) begin
      wa = $urandom_range(0, 47);
      cfg_we = 1'b1; cfg_addr = 6'(wa); cfg_data = 16'($urandom);
      mem_a[wa] = cfg_data; mem_b[wa] = cfg_data;
    end
    pa = model_run(1'b0, la, init);
    pb = model_run(1'b1, lb, init);
    for (int k = 0; k <= kend; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        start = 1'b0; cfg_we = 1'b0;
        check("valid_clr_a", psi_valid_a, 1'b0);
      end
      if (k == 2 && bw) begin
        cfg_we = 1'b0;
        check("busy_wr_err_a", cfg_err_a, 1'b1);
        check("busy_wr_err_b", cfg_err_b, 1'b1);
      end
      if (busy_a) ba++;
      if (busy_b) bb++;
      if (k >= 1 && k <= la) check("lidx_a", layer_idx_a, 64'(k-1));
      if (k >= 1 && k <= 3*lb) check("lidx_b", layer_idx_b, 64'((k-1)/3));
      if (done_a && da < 0) da = k;
      if (done_b && db < 0) db = k;
      if (k == ea + 1) begin
        check("done_pulse_a", done_a, 1'b0);
        check("psi_valid_a", psi_valid_a, 1'b1);
      end
      if (k == eb + 1) check("psi_valid_b", psi_valid_b, 1'b1);
      if (k == 1 && bw) begin
        wa = $urandom_range(0, 7);
        cfg_we = 1'b1; cfg_addr = 6'(wa); cfg_data = ~mem_a[wa];
      end
    end
    check("done_edge_a", 64'(da), 64'(ea));
    check("done_edge_b", 64'(db), 64'(eb));
    check("busy_cycles_a", 64'(ba), 64'(ea));
    check("busy_cycles_b", 64'(bb), 64'(eb));
    check("psi_a", psi_out_a, pa);
    check("psi_b", psi_out_b, pb);
  endtask

  localparam mat_t IDENT = {16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4000, 16'h0};
  localparam mat_t XGATE = {16'h0, 16'h0, 16'h4000, 16'h0, 16'h4000, 16'h0, 16'h0, 16'h0};
  localparam vec_t KET0  = {16'h4000, 16'h0, 16'h0, 16'h0};

  initial begin
    vec_t rv;
    int na, nb;
    bit bw;
    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_err", cfg_err_a, 1'b0);
    check("rst_valid", psi_valid_a, 1'b0);
    check("rst_lidx", layer_idx_a, 3'd0);
    check("rst_psi", psi_out_a, 64'd0);
    check("rst_busy_b", busy_b, 1'b0);
    rst = 1'b0;

    for (int l = 0; l < 3; l++) set_layer(l, IDENT);
    run(3, 3, KET0, 1'b0, 1'b0);
    check("ident_psi_a", psi_out_a, KET0);

    set_layer(0, XGATE);
    run(2, 2, KET0, 1'b0, 1'b0);
    check("x_psi_a", psi_out_a, {16'h0, 16'h0, 16'h4000, 16'h0});

    rv = {16'h1234, 16'h8765, 16'h0F0F, 16'hF00F};
    run(0, 0, rv, 1'b0, 1'b0);
    check("zero_layers_psi", psi_out_a, rv);

    for (int a = 0; a < 64; a++) cfg_write(a, 16'($urandom_range(0, 16'h7FFF) - 16'h4000));
    run(15, 7, KET0, 1'b0, 1'b0);
    run(3, 3, KET0, 1'b1, 1'b0);
    run(3, 3, KET0, 1'b0, 1'b0);

    cfg_write(48, 16'h2222);
    cfg_write(63, 16'h3333);
    @(posedge clk); #1;
    check("err_pulse_end_b", cfg_err_b, 1'b0);

    n_a = 4'd5; n_b = 3'd5; init_state = KET0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy_a", busy_a, 1'b0);
    check("abort_busy_b", busy_b, 1'b0);
    check("abort_psi_a", psi_out_a, 64'd0);
    check("abort_lidx_a", layer_idx_a, 3'd0);
    check("abort_valid_a", psi_valid_a, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("abort_no_done_a", done_a, 1'b0);
      check("abort_no_done_b", done_b, 1'b0);
    end
    run(5, 5, KET0, 1'b0, 1'b0);

    for (int it = 0; it < 16; it++) begin
      for (int w = 0; w < 4; w++) cfg_write($urandom_range(0, 63), 16'($urandom));
      rv = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      na = $urandom_range(0, 10);
      nb = $urandom_range(0, 7);
      bw = (na > 0) && (nb > 0) && ($urandom_range(0, 2) == 0);
      run(na, nb, rv, bw, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
